// File: rtl/btn_cond.sv
// Push-button conditioner: per-pin polarity fix, 2-FF sync and debounce; up/down
// shaped into mutually exclusive levels with auto-repeat gaps, select as a clean level.
module btn_cond #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned REP_DELAY  = 25000000,
  parameter int unsigned REP_PERIOD = 10000000,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_W      = 25,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic up_btn_i,
  input  logic down_btn_i,
  input  logic sel_btn_i,
  output logic up_o,
  output logic down_o,
  output logic sel_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    GAP   = 2'd2,
    RHELD = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REP_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [2:0] raw;
  logic [2:0] stable;
  logic [1:0] idle;
  logic [1:0] go;
  logic [1:0] lvl;

  // Channel order: 0 = up, 1 = down, 2 = select; raw is active-high from here on.
  assign raw = {sel_btn_i, down_btn_i, up_btn_i} ^ {3{ACTIVE_LOW}};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic             sync1_q;
    logic             sync2_q;
    logic             stb_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        stb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw[g];
        sync2_q <= sync1_q;
        if (sync2_q != stb_q) begin
          if (cnt_q == DEB_LAST) begin
            stb_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign stable[g] = stb_q;
  end

  // A channel may leave IDLE only while the other FSM is idle; up wins a tie.
  always_comb begin
    go    = '0;
    go[0] = stable[0] & idle[1];
    go[1] = stable[1] & idle[0] & ~go[0];
  end

  for (genvar g = 0; g < 2; g++) begin : g_fsm
    state_e           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        out_q <= 1'b0;
      end else if (!stable[g]) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        out_q <= 1'b0;
      end else begin
        case (st_q)
          IDLE: begin
            cnt_q <= '0;
            if (go[g]) begin
              st_q  <= HELD;
              out_q <= 1'b1;
            end else begin
              out_q <= 1'b0;
            end
          end
          HELD: begin
            if (cnt_q == DLY_LAST) begin
              st_q  <= GAP;
              cnt_q <= '0;
              out_q <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              out_q <= 1'b1;
            end
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              st_q  <= RHELD;
              cnt_q <= '0;
              out_q <= 1'b1;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              out_q <= 1'b0;
            end
          end
          RHELD: begin
            if (cnt_q == PER_LAST) begin
              st_q  <= GAP;
              cnt_q <= '0;
              out_q <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              out_q <= 1'b1;
            end
          end
          default: begin
            st_q  <= IDLE;
            cnt_q <= '0;
            out_q <= 1'b0;
          end
        endcase
      end
    end

    assign idle[g] = (st_q == IDLE);
    assign lvl[g]  = out_q;
  end

  assign up_o   = lvl[0];
  assign down_o = lvl[1];
  assign sel_o  = stable[2];

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond: directed per-cycle pin vectors with hand-derived
// expected output waveforms, compared by an independent negedge monitor.
module tb_btn_cond;

  localparam int N      = 256;
  // Repeat shape at DEB=4/REP_DELAY=20/REP_PERIOD=10/GAP=4: 20 high, then every 14: 4 low + 10 high.
  localparam int HOLD1  = 20;
  localparam int PERIOD = 14;
  localparam int GAPL   = 4;

  typedef bit [N-1:0] vec_t;
  typedef struct {
    int   seg;
    int   cyc;
    logic u;
    logic d;
    logic s;
  } exp_t;

  logic clk        = 1'b0;
  logic rst_i      = 1'b0;
  logic up_btn_i   = 1'b1;
  logic down_btn_i = 1'b1;
  logic sel_btn_i  = 1'b1;
  logic up_o;
  logic down_o;
  logic sel_o;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  string seg_name [8] = '{"reset_idle", "reset_mid", "glitch", "bounce",
                          "repeat", "arb_same", "arb_down_first", "sel_indep"};

  btn_cond #(
    .DEB_CYCLES (4),
    .REP_DELAY  (20),
    .REP_PERIOD (10),
    .GAP_CYCLES (4),
    .CNT_W      (8),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .up_btn_i   (up_btn_i),
    .down_btn_i (down_btn_i),
    .sel_btn_i  (sel_btn_i),
    .up_o       (up_o),
    .down_o     (down_o),
    .sel_o      (sel_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t rng(input int lo, input int hi);
    vec_t m = '0;
    for (int t = lo; t < hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Expected up/down level for an FSM output that rises at h and is forced low at e.
  function automatic vec_t rep(input int h, input int e);
    vec_t m = '0;
    for (int t = h; t < e; t++) begin
      int off = t - h;
      if (!(off >= HOLD1 && ((off - HOLD1) % PERIOD) < GAPL)) m[t] = 1'b1;
    end
    return m;
  endfunction

  task automatic play(input int seg, input int len,
                      input vec_t pu, input vec_t pd, input vec_t ps, input vec_t rs,
                      input vec_t eu, input vec_t ed, input vec_t es);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      rst_i      = ~rs[c];
      up_btn_i   = ~pu[c];
      down_btn_i = ~pd[c];
      sel_btn_i  = ~ps[c];
      sb.push_back('{seg, c, eu[c], ed[c], es[c]});
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({up_o, down_o, sel_o} !== {e.u, e.d, e.s}) begin
        n_err++;
        $display("FAIL %s cycle %0d: up/down/sel got %b%b%b expected %b%b%b",
                 seg_name[e.seg], e.cyc, up_o, down_o, sel_o, e.u, e.d, e.s);
      end
    end
  end

  initial begin
    vec_t z;
    vec_t b;
    z = '0;
    repeat (2) @(posedge clk);

    play(0, 12, z, z, z, rng(0, 4), z, z, z);

    // Async reset in cycle 14 kills up_o at once; released in 15, so re-debounce gives 22.
    play(1, 60, rng(2, 40), z, z, rng(14, 15),
         rng(9, 14) | rep(22, 47), z, z);

    play(2, 100, rng(2, 5) | rng(20, 28) | rng(45, 49), rng(60, 75), z, z,
         rng(27, 35) | rng(52, 56), rng(67, 82), z);

    b = rng(10, 25);
    b[0] = 1'b1; b[2] = 1'b1; b[4] = 1'b1; b[6] = 1'b1; b[8] = 1'b1;
    play(3, 50, b, z, z, z, rng(17, 32), z, z);

    // Release lands inside the last gap: no extra high.
    play(4, 95, rng(2, 68), z, z, z, rep(9, 75), z, z);

    // Up FSM idle in cycle 43, down enters HELD in 44.
    play(5, 95, rng(2, 36), rng(2, 70), z, z, rep(9, 43), rep(44, 77), z);

    play(6, 75, rng(10, 50), rng(2, 30), z, z, rep(38, 57), rep(9, 37), z);

    play(7, 100, rng(2, 80), z, rng(10, 20) | rng(30, 40) | rng(50, 60), z,
         rep(9, 87), z, rng(16, 26) | rng(36, 46) | rng(56, 66));

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
